// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Brief    : Load-and-shift sequencer; shifts an 8-bit operand right by 0-7
//            places (logical or arithmetic), one place per clock.
// Revision : 1.0
// ============================================================================
module shift_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] load_val,
    input  logic [2:0] amount,
    input  logic       arith,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [2:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] data,  data_nxt;
    logic [2:0] cnt,   cnt_nxt;
    logic       mode,  mode_nxt;
    logic       fill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            data  <= 8'h00;
            cnt   <= 3'd0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            cnt   <= cnt_nxt;
            mode  <= mode_nxt;
        end
    end

    assign fill = mode & data[7];

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        cnt_nxt   = cnt;
        mode_nxt  = mode;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    data_nxt  = load_val;
                    cnt_nxt   = amount;
                    mode_nxt  = arith;
                    state_nxt = (amount != 3'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // abort freezes the data at whatever has been shifted so far
                if (abort) begin
                    cnt_nxt   = 3'd0;
                    state_nxt = IDLE;
                end else begin
                    data_nxt = {fill, data[7:1]};
                    cnt_nxt  = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy   = (state == SHIFT) || (state == DONE);
    assign done   = (state == DONE);
    assign result = data;
    assign count  = (state == SHIFT) ? cnt : 3'd0;

endmodule
`default_nettype wire
